// File: rtl/uart_cmd_if.sv
// UART host link: RX byte pairs become 16-bit commands, TX serializes response bytes (8N1, LSB first).
// Optional `UART_CMD_TIMEOUT_EN drops a stale high byte if the low byte never arrives.
module uart_cmd_if #(
  parameter int BAUD_DIV = 868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic       {TX_IDLE, TX_XMIT} tx_state_e;

  // ---------------- RX synchronizer ----------------
  logic rx_meta_q, rx_sync_q, rx_prev_q;
  logic rx_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign rx_fall = rx_prev_q & ~rx_sync_q;

  // ---------------- RX FSM ----------------
  rx_state_e     rx_state_q;
  logic [CW-1:0] rx_cnt_q;
  logic [3:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;
  logic          byte_vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      byte_vld_q <= 1'b0;
    end else begin
      byte_vld_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_state_q <= RX_START;
            rx_cnt_q   <= '0;
          end
        end
        RX_START: begin
          // A high mid-start sample means a glitch, not a frame.
          if (rx_cnt_q == HALF_M1) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == FULL_M1) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 1'b1;
            if (rx_bit_q == 4'd7) rx_state_q <= RX_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == FULL_M1) begin
            rx_cnt_q   <= '0;
            byte_vld_q <= rx_sync_q;
            rx_state_q <= RX_IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // ---------------- byte pair assembly ----------------
  logic [7:0]  hi_q;
  logic        hi_done_q;
  logic [15:0] cmd_q;
  logic        cmd_rdy_q;
  logic        cmd_done;

  assign cmd_done = byte_vld_q & hi_done_q;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TMO = 20 * BAUD_DIV;
  localparam int TW  = $clog2(TMO);
  logic [TW-1:0] tmo_cnt_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q      <= '0;
      hi_done_q <= 1'b0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
`ifdef UART_CMD_TIMEOUT_EN
      // Counter only runs while waiting idle for the low byte's start bit.
      if (!hi_done_q || byte_vld_q) begin
        tmo_cnt_q <= '0;
      end else if (rx_state_q == RX_IDLE) begin
        if (tmo_cnt_q == TW'(TMO - 1)) begin
          tmo_cnt_q <= '0;
          hi_done_q <= 1'b0;
        end else begin
          tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
      end
`endif
      if (byte_vld_q) begin
        if (!hi_done_q) begin
          hi_q      <= rx_shift_q;
          hi_done_q <= 1'b1;
        end else begin
          cmd_q     <= {hi_q, rx_shift_q};
          hi_done_q <= 1'b0;
        end
      end
      if (cmd_done)         cmd_rdy_q <= 1'b1;
      else if (clr_cmd_rdy) cmd_rdy_q <= 1'b0;
    end
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;

  // ---------------- TX FSM ----------------
  // The shift register idles all-ones so its LSB is the TX pin directly.
  tx_state_e     tx_state_q;
  logic [9:0]    tx_shift_q;
  logic [CW-1:0] tx_cnt_q;
  logic [3:0]    tx_bit_q;
  logic          resp_sent_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q  <= TX_IDLE;
      tx_shift_q  <= '1;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      resp_sent_q <= 1'b0;
    end else begin
      resp_sent_q <= 1'b0;
      if (tx_state_q == TX_IDLE) begin
        if (send_resp) begin
          tx_shift_q <= {1'b1, resp, 1'b0};
          tx_cnt_q   <= '0;
          tx_bit_q   <= '0;
          tx_state_q <= TX_XMIT;
        end
      end else begin
        if (tx_cnt_q == FULL_M1) begin
          tx_cnt_q   <= '0;
          tx_shift_q <= {1'b1, tx_shift_q[9:1]};
          if (tx_bit_q == 4'd9) begin
            tx_state_q  <= TX_IDLE;
            resp_sent_q <= 1'b1;
          end else begin
            tx_bit_q <= tx_bit_q + 1'b1;
          end
        end else begin
          tx_cnt_q <= tx_cnt_q + 1'b1;
        end
      end
    end
  end

  assign TX        = tx_shift_q[0];
  assign resp_sent = resp_sent_q;

endmodule

// File: tb/tb_uart_cmd_if.sv
// Scoreboard bench for uart_cmd_if at BAUD_DIV=16: directed RX commands and TX frames.
module tb_uart_cmd_if;
  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst_n, RX, TX, cmd_rdy, clr_cmd_rdy, send_resp, resp_sent;
  logic [15:0] cmd;
  logic [7:0]  resp;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] cmd_exp_q[$];
  logic [7:0]  tx_exp_q[$];

  always #5 clk = ~clk;

  uart_cmd_if #(.BAUD_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp), .resp_sent(resp_sent)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pin goes low just after edge E0; stop sample falls at E155, completion at E156.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(posedge clk); #1 RX = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (BD) @(posedge clk);
      #1 RX = b[i];
    end
    repeat (BD) @(posedge clk); #1 RX = stop_bit;
    repeat (BD) @(posedge clk); #1 RX = 1'b1;
  endtask

  task automatic clr_pulse();
    @(posedge clk); #1 clr_cmd_rdy = 1'b1;
    @(posedge clk); #1 clr_cmd_rdy = 1'b0;
    @(negedge clk);
    chk("rdy_cleared", cmd_rdy, 1'b0);
  endtask

  task automatic wait_resp_sent(input string name);
    int n;
    n = 0;
    while (resp_sent !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(name, resp_sent, 1'b1);
  endtask

  // Command monitor: a rise of cmd_rdy or a new cmd while ready is one completion.
  initial begin
    logic [15:0] prev_cmd, e;
    logic        prev_rdy;
    prev_cmd = '0;
    prev_rdy = 1'b0;
    @(posedge rst_n);
    forever begin
      @(negedge clk);
      if (cmd_rdy === 1'b1 && (!prev_rdy || cmd !== prev_cmd)) begin
        if (cmd_exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL cmd_unexpected: got %h expected no command", cmd);
        end else begin
          e = cmd_exp_q.pop_front();
          chk("cmd_value", cmd, e);
        end
      end
      prev_cmd = cmd;
      prev_rdy = cmd_rdy;
    end
  end

  // TX monitor: each bit must hold for BD clocks, resp_sent exactly after the stop bit.
  initial begin
    logic [9:0] fr;
    logic [7:0] b;
    logic       ok;
    @(posedge rst_n);
    forever begin
      @(negedge clk);
      if (TX === 1'b0) begin
        if (tx_exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL tx_unexpected_frame: got TX=0 expected idle 1");
          repeat (10 * BD) @(negedge clk);
        end else begin
          b  = tx_exp_q.pop_front();
          fr = {1'b1, b, 1'b0};
          for (int i = 0; i < 10; i++) begin
            ok = 1'b1;
            for (int k = 0; k < BD; k++) begin
              if (TX !== fr[i] || resp_sent !== 1'b0) ok = 1'b0;
              @(negedge clk);
            end
            chk($sformatf("tx_bit%0d_of_%h", i, b), ok, 1'b1);
          end
          chk("resp_sent_pulse", resp_sent, 1'b1);
          chk("tx_idle_after_frame", TX, 1'b1);
          @(negedge clk);
          chk("resp_sent_one_clk", resp_sent, 1'b0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; RX = 1'b1; clr_cmd_rdy = 1'b0; send_resp = 1'b0; resp = '0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_tx", TX, 1'b1);
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_cmd_rdy", cmd_rdy, 1'b0);
    chk("rst_resp_sent", resp_sent, 1'b0);

    // Basic command, held until cleared
    cmd_exp_q.push_back(16'hA53C);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("rdy_held", cmd_rdy, 1'b1);
    chk("cmd_held", cmd, 16'hA53C);
    clr_pulse();

    // Clear in the completion cycle loses to completion
    cmd_exp_q.push_back(16'h1234);
    send_byte(8'h12, 1'b1);
    fork
      send_byte(8'h34, 1'b1);
      begin
        @(posedge clk);
        repeat (155) @(posedge clk);
        #1 clr_cmd_rdy = 1'b1;
        @(posedge clk);
        #1 clr_cmd_rdy = 1'b0;
      end
    join
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rdy_wins_over_clr", cmd_rdy, 1'b1);
    clr_pulse();

    // Framing error byte is dropped
    cmd_exp_q.push_back(16'h1234);
    send_byte(8'h55, 1'b0);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    repeat (5) @(posedge clk);
    clr_pulse();

    // 3-clock glitch must not become a byte
    @(posedge clk); #1 RX = 1'b0;
    repeat (3) @(posedge clk); #1 RX = 1'b1;
    repeat (200) @(posedge clk);
    @(negedge clk);
    chk("glitch_no_cmd", cmd_rdy, 1'b0);
    cmd_exp_q.push_back(16'h5678);
    send_byte(8'h56, 1'b1);
    send_byte(8'h78, 1'b1);
    repeat (5) @(posedge clk);
    clr_pulse();

    // TX: 0xA5, ignored request mid-frame, then back-to-back 0x3C
    tx_exp_q.push_back(8'hA5);
    @(posedge clk); #1 resp = 8'hA5; send_resp = 1'b1;
    @(posedge clk); #1 send_resp = 1'b0;
    repeat (50) @(posedge clk);
    #1 resp = 8'h0F; send_resp = 1'b1;
    @(posedge clk); #1 send_resp = 1'b0;
    wait_resp_sent("resp_sent_a5");
    tx_exp_q.push_back(8'h3C);
    @(posedge clk); #1 resp = 8'h3C; send_resp = 1'b1;
    @(posedge clk); #1 send_resp = 1'b0;
    wait_resp_sent("resp_sent_3c");
    repeat (40) @(posedge clk);

    // Stale high byte
`ifdef UART_CMD_TIMEOUT_EN
    cmd_exp_q.push_back(16'hABCD);
`else
    cmd_exp_q.push_back(16'hFFAB);
`endif
    send_byte(8'hFF, 1'b1);
    repeat (400) @(posedge clk);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    repeat (50) @(posedge clk);

    while (cmd_exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL cmd_missing: got nothing expected %h", cmd_exp_q.pop_front());
    end
    while (tx_exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL tx_missing: got nothing expected frame %h", tx_exp_q.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_cmd_if.md
# uart_cmd_if

Serial host interface for the logic analyzer. It receives a UART byte stream from the host on `RX`, assembles byte pairs into the 16-bit `cmd` word consumed by the digital core's command/config unit, and holds `cmd_rdy` until that unit acknowledges with `clr_cmd_rdy`. It also serializes each 8-bit `resp` byte onto `TX` when `send_resp` is pulsed, and returns `resp_sent` on completion. The block sits directly upstream of the digital core, on the board-level `RX`/`TX` pins.

## Interface
- `BAUD_DIV`, 868, clocks per bit (100 MHz / 115200); minimum 16; simulation uses 16.
- `clk`  in  1  100 MHz system clock
- `rst_n`  in  1  asynchronous active-low reset
- `RX`  in  1  serial input from host, asynchronous, idle high
- `TX`  out  1  serial output to host, idle high
- `cmd`  out  16  assembled command; first byte received is `[15:8]`, second is `[7:0]`
- `cmd_rdy`  out  1  `cmd` valid, held until cleared
- `clr_cmd_rdy`  in  1  single-cycle acknowledge from the command unit
- `resp`  in  8  response byte to transmit
- `send_resp`  in  1  single-cycle request to transmit `resp`
- `resp_sent`  out  1  single-cycle pulse when the stop bit of `resp` completes

## Operation
- Frame format for both directions: 8N1, LSB first.
- RX path:
  - `RX` passes through a 2-flop synchronizer; reset value of the synchronizer flops is 1.
  - RX FSM states are IDLE, START, DATA, STOP.
  - IDLE→START on a synchronized falling edge.
  - In START, sample at `BAUD_DIV/2` (integer division). If the sample is high, the start bit is false: return to IDLE with no byte.
  - DATA samples 8 bits, one every `BAUD_DIV` clocks, into a shift register.
  - STOP samples once. High: byte valid. Low: framing error; the byte is discarded and the assembly state is left unchanged.
  - After the STOP sample, return to IDLE.
- Byte assembly:
  - A 1-bit `hi_done` flag tracks progress.
  - First valid byte: latch into the high-byte register and set `hi_done`.
  - Second valid byte: `cmd <= {hi, byte}`, `cmd_rdy <= 1`, clear `hi_done`.
- `cmd_rdy`:
  - Set on completion, cleared by `clr_cmd_rdy`.
  - If completion and clear occur in the same cycle, completion wins and `cmd_rdy` stays 1.
  - A new command completing while `cmd_rdy` = 1 overwrites `cmd`; `cmd_rdy` stays 1 and no error is reported.
- TX path:
  - TX FSM states are IDLE, XMIT.
  - `send_resp` in IDLE loads `{1'b1, resp, 1'b0}` into a 10-bit shift register and enters XMIT.
  - `send_resp` during XMIT is ignored.
  - The register shifts every `BAUD_DIV` clocks; the frame is complete after 10 bit periods, then the FSM returns to IDLE.
- Reset values: `TX`=1, `cmd`=0, `cmd_rdy`=0, `resp_sent`=0, `hi_done`=0, both FSMs IDLE, all counters 0.
- A reset mid-frame aborts both paths immediately. Any partial byte or half-assembled command is lost.

## Timing
- RX:
  - The falling edge on the `RX` pin is visible to the FSM 2 clocks later (synchronizer delay).
  - The data-bit-0 sample lands `BAUD_DIV/2 + BAUD_DIV` clocks after the detected edge.
  - `cmd_rdy` rises on the clock after the second byte's stop-bit sample.
- TX:
  - `send_resp` is sampled at edge N; `TX` goes low (start bit) from edge N+1.
  - Each bit is held exactly `BAUD_DIV` clocks.
  - `resp_sent` is high for exactly 1 clock: the cycle in which the stop bit's period ends. The FSM is IDLE in that same cycle.
  - A `send_resp` in the cycle after `resp_sent` is accepted.
- RX and TX are fully independent and may run concurrently.
- Baud counters are `$clog2(BAUD_DIV)` bits wide. Bit counters are 4 bits.

## Configuration
- `UART_CMD_TIMEOUT_EN`:
  - Defined: while `hi_done` = 1, a counter runs. If no second start bit is detected within `20*BAUD_DIV` clocks of the first byte's stop sample, `hi_done` clears. The next byte is then treated as a high byte, which resynchronizes a host that dropped a byte.
  - Undefined: no counter; `hi_done` persists indefinitely until the second byte or reset.

## Test plan
- Reset: after `rst_n` deasserts, `TX`=1, `cmd`=0x0000, `cmd_rdy`=0, `resp_sent`=0.
- RX command: `BAUD_DIV`=16, send bytes 0xA5 then 0x3C → `cmd`=0xA53C, `cmd_rdy`=1 and held; `clr_cmd_rdy` pulse → `cmd_rdy`=0 the next clock.
- Simultaneous events:
  - Assert `clr_cmd_rdy` in the exact cycle of a second command's completion (0x1234) → `cmd_rdy` stays 1, `cmd`=0x1234.
  - Drive a 3-clock low glitch on `RX` → no byte is accepted.
- Framing error: send 0x55 with stop bit low, then 0x12, 0x34 → `cmd`=0x1234 (errored byte ignored).
- TX: `send_resp` with `resp`=0xA5 → `TX` shows 0,1,0,1,0,0,1,0,1,1, each for 16 clocks; `resp_sent` is a 1-clock pulse after 160 clocks; a second `send_resp` during XMIT produces no extra frame.
- Timeout (macro defined): send 0xFF, idle 400 clocks, then send 0xAB, 0xCD → `cmd`=0xABCD. Without the macro, the same stimulus yields `cmd`=0xFFAB.
